rtc_bus_engine: RTL and testbench
=================================

# rtc_bus_engine

Physical-side engine of the RTC path. Takes the write/read requests raised by the RTC main controller (`actesc`/`actlec` with a latched address and data byte) and runs the multiplexed address/data bus cycle on the external RTC chip. Returns a level completion handshake (`esclisto`/`memorialisto`) and, for reads, the byte fetched from the chip (`datomem`).

## Interface
- T_SETUP, 2: cycles CS/AD/bus are valid before the strobe falls, per phase (≥1)
- T_PULSE, 5: strobe-low width in cycles, per phase (≥1)
- T_HOLD, 2: cycles bus/CS are held after the strobe rises, per phase (≥1)
- T_GAP, 3: CS-high cycles between the address and data phases, and after the data phase (≥1)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- actesc  in  1  write request, level, held until `esclisto` is seen
- actlec  in  1  read request, level, held until `memorialisto` is seen
- dirreg  in  8  RTC register address
- datoreg  in  8  write data
- esclisto  out  1  write complete, level
- memorialisto  out  1  read complete, level
- datomem  out  8  last byte read from the RTC
- cs_rtc  out  1  chip select, active-low
- rd_rtc  out  1  read strobe, active-low
- wr_rtc  out  1  write strobe, active-low
- ad_rtc  out  1  address/data select: 0 = address phase, 1 = data phase
- bus_out  out  8  value driven onto the AD bus
- bus_oe  out  1  bus output enable (1 = drive `bus_out`)
- bus_in  in  8  AD bus read-back from the pad

## Operation
- All outputs are registered.
- Reset values:
  - `cs_rtc`, `rd_rtc`, `wr_rtc` and `ad_rtc` = 1.
  - `bus_out`, `bus_oe`, `esclisto`, `memorialisto` and `datomem` = 0.
  - State = IDLE.
- States: IDLE, A_SETUP, A_PULSE, A_HOLD, GAP, D_SETUP, D_PULSE, D_HOLD, RECOVER, DONE. An 8-bit down-counter is loaded on entry to each timed state.
- IDLE:
  - `actesc`=1 starts a write. Otherwise `actlec`=1 starts a read. If both are 1, the write wins.
  - On start, `dirreg` and `datoreg` are captured into internal registers and the type (write/read) is latched. Inputs may change afterwards.
- Address phase (both types): `ad_rtc`=0, `cs_rtc`=0, `bus_oe`=1, `bus_out`=captured address, and `wr_rtc`=0 only during A_PULSE.
- GAP: `cs_rtc`=1, `bus_oe`=0, strobes high.
- Data phase: `ad_rtc`=1, `cs_rtc`=0.
  - Write: `bus_oe`=1, `bus_out`=captured data, `wr_rtc`=0 during D_PULSE.
  - Read: `bus_oe`=0, `rd_rtc`=0 during D_PULSE. `datomem` loads `bus_in` on the last D_PULSE cycle.
- RECOVER: same bus state as GAP.
- DONE: `esclisto`=1 (write) or `memorialisto`=1 (read), held until the matching request is 0. Then return to IDLE, deasserting the flag.
- Four-phase handshake: a new request is only accepted in IDLE. `datomem` holds its value until the next read overwrites it.
- Request dropped mid-transaction: the bus cycle still completes. DONE then sees the request low and the completion flag is high for exactly 1 cycle.
- `bus_oe` must never be 1 while `rd_rtc`=0.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously) and the captured transaction is abandoned.

## Timing
- Edge N samples the request in IDLE. A_SETUP is active from edge N for T_SETUP cycles, then A_PULSE for T_PULSE, A_HOLD for T_HOLD, GAP for T_GAP, D_SETUP, D_PULSE, D_HOLD, and RECOVER for T_GAP.
- The completion flag rises at edge N + 2·(T_SETUP+T_PULSE+T_HOLD+T_GAP). With defaults this is N+24.
- Strobe low width = T_PULSE cycles exactly. Address/data is stable T_SETUP cycles before and T_HOLD cycles after each strobe.
- Read sample point: edge N + T_SETUP+T_PULSE+T_HOLD+T_GAP+T_SETUP+T_PULSE. `datomem` is valid from that edge.
- Minimum turnaround: after the request falls, the flag clears 1 cycle later. A new request is sampled on the following edge at the earliest.

## Test plan
- Reset values: hold `reset`=0 with toggling inputs -> all outputs at reset values. Release, no request -> outputs unchanged for 50 cycles.
- Write: `actesc`=1, `dirreg`=0x21, `datoreg`=0x15 (defaults):
  - Bus sequence: `wr_rtc` low 5 cycles with `ad_rtc`=0 and `bus_out`=0x21, then after 3 CS-high cycles `wr_rtc` low 5 cycles with `ad_rtc`=1 and `bus_out`=0x15.
  - `esclisto`=1 at N+24 and held until `actesc`=0.
- Read: `actlec`=1, `dirreg`=0x41, `bus_in`=0x37 during D_PULSE -> `rd_rtc` low 5 cycles with `bus_oe`=0, `datomem`=0x37, `memorialisto`=1 at N+24. Change `bus_in` to 0x00 afterwards -> `datomem` stays 0x37.
- Simultaneous: `actesc`=`actlec`=1 in the same cycle -> a write is performed and only `esclisto` asserts. The read runs after the handshake completes.
- Early drop: `actesc` falls during A_PULSE -> bus cycle completes, `esclisto` high exactly 1 cycle.
- Reset mid-read: `reset`=0 during D_PULSE -> `rd_rtc`/`cs_rtc` go to 1 asynchronously, `datomem`=0. After release with `actlec`=0 -> stays in IDLE.

Source files
------------

// File: rtl/rtc_bus_engine.sv
// Multiplexed address/data bus engine for the external RTC chip.
// One request per four-phase handshake: address phase, CS gap, data phase, recovery, then completion flag.
module rtc_bus_engine #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 5,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_GAP   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       actesc,
  input  logic       actlec,
  input  logic [7:0] dirreg,
  input  logic [7:0] datoreg,
  output logic       esclisto,
  output logic       memorialisto,
  output logic [7:0] datomem,
  output logic       cs_rtc,
  output logic       rd_rtc,
  output logic       wr_rtc,
  output logic       ad_rtc,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in
);

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_PULSE, A_HOLD, GAP, D_SETUP, D_PULSE, D_HOLD, RECOVER, DONE
  } state_t;

  localparam logic [7:0] C_SETUP = 8'(T_SETUP - 1);
  localparam logic [7:0] C_PULSE = 8'(T_PULSE - 1);
  localparam logic [7:0] C_HOLD  = 8'(T_HOLD - 1);
  localparam logic [7:0] C_GAP   = 8'(T_GAP - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_is_wr;
  logic [7:0] r_data;

  logic w_cnt_zero;
  logic w_req;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_req      = r_is_wr ? actesc : actlec;

  // Outputs are set on the transition into each state so they are valid from its first cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_is_wr      <= 1'b0;
      r_data       <= '0;
      cs_rtc       <= 1'b1;
      rd_rtc       <= 1'b1;
      wr_rtc       <= 1'b1;
      ad_rtc       <= 1'b1;
      bus_out      <= '0;
      bus_oe       <= 1'b0;
      esclisto     <= 1'b0;
      memorialisto <= 1'b0;
      datomem      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (actesc || actlec) begin
            r_is_wr <= actesc;
            r_data  <= datoreg;
            bus_out <= dirreg;
            bus_oe  <= 1'b1;
            cs_rtc  <= 1'b0;
            ad_rtc  <= 1'b0;
            r_cnt   <= C_SETUP;
            r_state <= A_SETUP;
          end
        end
        A_SETUP: begin
          if (w_cnt_zero) begin
            wr_rtc  <= 1'b0;
            r_cnt   <= C_PULSE;
            r_state <= A_PULSE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        A_PULSE: begin
          if (w_cnt_zero) begin
            wr_rtc  <= 1'b1;
            r_cnt   <= C_HOLD;
            r_state <= A_HOLD;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        A_HOLD: begin
          if (w_cnt_zero) begin
            cs_rtc  <= 1'b1;
            ad_rtc  <= 1'b1;
            bus_oe  <= 1'b0;
            r_cnt   <= C_GAP;
            r_state <= GAP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        GAP: begin
          if (w_cnt_zero) begin
            cs_rtc  <= 1'b0;
            ad_rtc  <= 1'b1;
            bus_oe  <= r_is_wr;
            bus_out <= r_data;
            r_cnt   <= C_SETUP;
            r_state <= D_SETUP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        D_SETUP: begin
          if (w_cnt_zero) begin
            wr_rtc  <= ~r_is_wr;
            rd_rtc  <= r_is_wr;
            r_cnt   <= C_PULSE;
            r_state <= D_PULSE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        D_PULSE: begin
          if (w_cnt_zero) begin
            wr_rtc <= 1'b1;
            rd_rtc <= 1'b1;
            if (!r_is_wr) begin
              datomem <= bus_in;
            end
            r_cnt   <= C_HOLD;
            r_state <= D_HOLD;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        D_HOLD: begin
          if (w_cnt_zero) begin
            cs_rtc  <= 1'b1;
            bus_oe  <= 1'b0;
            r_cnt   <= C_GAP;
            r_state <= RECOVER;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        RECOVER: begin
          if (w_cnt_zero) begin
            esclisto     <= r_is_wr;
            memorialisto <= ~r_is_wr;
            r_state      <= DONE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        DONE: begin
          if (!w_req) begin
            esclisto     <= 1'b0;
            memorialisto <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_engine.sv
// Bench for rtc_bus_engine: a timeline model (cycle offset into the transaction) checked every cycle,
// plus directed scenarios with hand-computed expectations and a randomized handshake stream.
module tb_rtc_bus_engine;

  localparam int unsigned TS = 2, TP = 5, TH = 2, TG = 3;
  localparam int unsigned L  = TS + TP + TH;     // one phase
  localparam int unsigned M  = L + TG;           // data phase start offset
  localparam int unsigned KSAMP = M + TS + TP;   // read sample edge offset
  localparam int unsigned KDONE = 2 * M;         // completion edge offset

  logic       clk, reset, actesc, actlec;
  logic [7:0] dirreg, datoreg, bus_in;
  logic       esclisto, memorialisto, cs_rtc, rd_rtc, wr_rtc, ad_rtc, bus_oe;
  logic [7:0] datomem, bus_out;

  rtc_bus_engine #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_GAP(TG)) dut (
    .clk(clk), .reset(reset), .actesc(actesc), .actlec(actlec),
    .dirreg(dirreg), .datoreg(datoreg), .esclisto(esclisto),
    .memorialisto(memorialisto), .datomem(datomem), .cs_rtc(cs_rtc),
    .rd_rtc(rd_rtc), .wr_rtc(wr_rtc), .ad_rtc(ad_rtc), .bus_out(bus_out),
    .bus_oe(bus_oe), .bus_in(bus_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
  endtask

  // Bus read-back driver: random noise or a fixed pattern.
  bit         rnd_bus = 1'b0;
  logic [7:0] bus_fix = 8'h00;
  always @(negedge clk) bus_in = rnd_bus ? 8'($urandom) : bus_fix;

  // Behavioural model: transaction timeline measured in edges since the start edge.
  bit          m_busy = 1'b0, m_done = 1'b0, m_wr = 1'b0;
  int unsigned m_k = 0;
  logic [7:0]  m_addr = '0, m_data = '0, m_dat = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_dat  = '0;
    end else if (m_done) begin
      if (!(m_wr ? actesc : actlec)) m_done = 1'b0;
    end else if (m_busy) begin
      m_k++;
      if (!m_wr && m_k == KSAMP) m_dat = bus_in;
      if (m_k == KDONE) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (actesc || actlec) begin
      m_busy = 1'b1;
      m_k    = 0;
      m_wr   = actesc;
      m_addr = dirreg;
      m_data = datoreg;
    end
  end

  always @(negedge clk) begin
    logic       e_cs, e_ad, e_oe, e_wr, e_rd, e_bchk;
    logic [7:0] e_bo;
    int unsigned j;
    e_cs = 1; e_ad = 1; e_oe = 0; e_wr = 1; e_rd = 1; e_bchk = 0; e_bo = '0;
    if (m_busy) begin
      if (m_k < L) begin
        e_cs = 0; e_ad = 0; e_oe = 1; e_bchk = 1; e_bo = m_addr;
        if (m_k >= TS && m_k < TS + TP) e_wr = 0;
      end else if (m_k >= M && m_k < M + L) begin
        j = m_k - M;
        e_cs = 0; e_ad = 1; e_oe = m_wr;
        if (m_wr) begin
          e_bchk = 1; e_bo = m_data;
          if (j >= TS && j < TS + TP) e_wr = 0;
        end else if (j >= TS && j < TS + TP) begin
          e_rd = 0;
        end
      end
    end
    chk("cs_rtc", 8'(cs_rtc), 8'(e_cs));
    chk("ad_rtc", 8'(ad_rtc), 8'(e_ad));
    chk("bus_oe", 8'(bus_oe), 8'(e_oe));
    chk("wr_rtc", 8'(wr_rtc), 8'(e_wr));
    chk("rd_rtc", 8'(rd_rtc), 8'(e_rd));
    if (e_bchk) chk("bus_out", bus_out, e_bo);
    chk("esclisto", 8'(esclisto), 8'(m_done && m_wr));
    chk("memorialisto", 8'(memorialisto), 8'(m_done && !m_wr));
    chk("datomem", datomem, m_dat);
    chk("oe_vs_rd", 8'(bus_oe && !rd_rtc), 8'h00);
  end

  function automatic logic sig(input int sel);
    case (sel)
      0: return esclisto;
      1: return memorialisto;
      2: return wr_rtc;
      3: return rd_rtc;
      default: return esclisto | memorialisto;
    endcase
  endfunction

  // Waits on negedges until sig(sel)==val; returns the number of negedges consumed.
  task automatic wait_sig(input int sel, input logic val, input int unsigned max_cyc,
                          input string nm, output int unsigned n);
    n = 0;
    while (sig(sel) !== val) begin
      if (n >= max_cyc) begin
        timeout(nm);
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  int unsigned n, nlow, noe, nhi;
  logic [7:0]  a_seen, d_seen;

  initial begin
    reset = 0; actesc = 0; actlec = 0; dirreg = '0; datoreg = '0;
    // Reset with toggling inputs
    repeat (6) begin
      @(negedge clk);
      actesc = 1'($urandom); actlec = 1'($urandom);
      dirreg = 8'($urandom); datoreg = 8'($urandom); bus_fix = 8'($urandom);
    end
    #1;
    chk("rst_bus_out", bus_out, 8'h00);
    chk("rst_strobes", {5'b0, cs_rtc, rd_rtc, wr_rtc}, 8'h07);
    @(negedge clk);
    actesc = 0; actlec = 0; bus_fix = 8'h00;
    #2 reset = 1;
    repeat (50) @(negedge clk);
    chk("idle50_bus_out", bus_out, 8'h00);
    chk("idle50_ad", 8'(ad_rtc), 8'h01);

    // Directed write
    actesc = 1; dirreg = 8'h21; datoreg = 8'h15;
    n = 0; nlow = 0; a_seen = '0; d_seen = '0;
    @(negedge clk); n++;
    dirreg = 8'hFF; datoreg = 8'h00;
    while (!esclisto && n < 60) begin
      @(negedge clk); n++;
      if (!wr_rtc) begin
        nlow++;
        if (!ad_rtc) a_seen = bus_out; else d_seen = bus_out;
      end
    end
    chk("wr_latency", 8'(n), 8'd25);
    chk("wr_low_cycles", 8'(nlow), 8'd10);
    chk("wr_addr_on_bus", a_seen, 8'h21);
    chk("wr_data_on_bus", d_seen, 8'h15);
    repeat (4) @(negedge clk);
    chk("wr_flag_held", 8'(esclisto), 8'h01);
    actesc = 0;
    @(negedge clk);
    @(negedge clk);
    chk("wr_flag_clear", 8'(esclisto), 8'h00);

    // Directed read
    actlec = 1; dirreg = 8'h41; bus_fix = 8'h37;
    n = 0; nlow = 0; noe = 0;
    @(negedge clk); n++;
    while (!memorialisto && n < 60) begin
      @(negedge clk); n++;
      if (!rd_rtc) begin
        nlow++;
        if (bus_oe) noe++;
      end
    end
    chk("rd_latency", 8'(n), 8'd25);
    chk("rd_low_cycles", 8'(nlow), 8'd5);
    chk("rd_oe_during_rd", 8'(noe), 8'd0);
    chk("rd_datomem", datomem, 8'h37);
    actlec = 0; bus_fix = 8'h00;
    repeat (5) @(negedge clk);
    chk("rd_datomem_hold", datomem, 8'h37);

    // Simultaneous: write wins, read follows
    actesc = 1; actlec = 1; dirreg = 8'h5A; datoreg = 8'hA5; bus_fix = 8'h6C;
    @(negedge clk);
    wait_sig(4, 1'b1, 40, "sim_first_flag", n);
    chk("sim_esclisto", 8'(esclisto), 8'h01);
    chk("sim_no_mem", 8'(memorialisto), 8'h00);
    actesc = 0;
    @(negedge clk);
    wait_sig(1, 1'b1, 45, "sim_read_flag", n);
    chk("sim_read_dat", datomem, 8'h6C);
    actlec = 0;
    @(negedge clk);

    // Early drop during A_PULSE
    @(negedge clk);
    actesc = 1; datoreg = 8'h3C;
    wait_sig(2, 1'b0, 20, "drop_wr_low", n);
    actesc = 0;
    wait_sig(0, 1'b1, 40, "drop_flag", n);
    nhi = 0;
    while (esclisto && nhi < 10) begin
      @(negedge clk); nhi++;
    end
    chk("drop_flag_width", 8'(nhi), 8'd1);

    // Reset during D_PULSE of a read
    @(negedge clk);
    actlec = 1; bus_fix = 8'h99;
    wait_sig(3, 1'b0, 40, "rst_rd_low", n);
    #2 reset = 0;
    #1;
    chk("arst_rd", 8'(rd_rtc), 8'h01);
    chk("arst_cs", 8'(cs_rtc), 8'h01);
    chk("arst_datomem", datomem, 8'h00);
    actlec = 0;
    repeat (3) @(negedge clk);
    #2 reset = 1;
    repeat (10) @(negedge clk);
    chk("arst_idle_cs", 8'(cs_rtc), 8'h01);
    chk("arst_idle_flag", 8'(memorialisto), 8'h00);

    // Randomized handshake stream
    rnd_bus = 1'b1;
    for (int t = 0; t < 60; t++) begin
      bit both, is_wr, early;
      both  = ($urandom_range(0, 7) == 0);
      is_wr = 1'($urandom);
      early = ($urandom_range(0, 3) == 0);
      dirreg = 8'($urandom); datoreg = 8'($urandom);
      if (both) begin actesc = 1; actlec = 1; end
      else if (is_wr) actesc = 1;
      else actlec = 1;
      @(negedge clk);
      dirreg = 8'($urandom); datoreg = 8'($urandom);
      if (early) begin
        repeat ($urandom_range(1, 22)) @(negedge clk);
      end else begin
        wait_sig(4, 1'b1, 80, "rnd_flag", n);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      actesc = 0; actlec = 0;
      wait_sig(4, 1'b0, 80, "rnd_flag_clear", n);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
